// File: rtl/hdr_parser.sv
// Header parser: forwards packets unchanged while extracting up to ten header fields into a PHV,
// steered by a VLAN-indexed action table that is programmed over the control stream.
module hdr_parser #(
  parameter int         C_AXIS_DATA_WIDTH  = 256,
  parameter int         C_AXIS_TUSER_WIDTH = 128,
  parameter int         C_PKT_VEC_WIDTH    = 1124,
  parameter logic [2:0] PARSER_MOD_ID      = 3'b001
) (
  input  logic                            clk,
  input  logic                            areset,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [C_PKT_VEC_WIDTH-1:0]      phv_out,
  output logic                            phv_valid,
  input  logic                            phv_ready,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    ctrl_s_axis_tdata,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   ctrl_s_axis_tuser,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  ctrl_s_axis_tkeep,
  input  logic                            ctrl_s_axis_tvalid,
  input  logic                            ctrl_s_axis_tlast
);
  localparam int DW    = C_AXIS_DATA_WIDTH;
  localparam int BUF_W = 4*DW;
  localparam int ENT_W = 160;

  typedef enum logic [2:0] {HDR_0, HDR_1, HDR_2, HDR_3, LOOKUP, EXTRACT, EMIT_PHV, PAYLOAD} state_t;
  typedef enum logic [1:0] {C_IDLE, C_HDR, C_DATA} cstate_t;

  state_t                  r_state, w_state_nxt;
  cstate_t                 r_cstate, w_cstate_nxt;
  logic [BUF_W-1:0]        r_hdr;
  logic [BUF_W+47:0]       w_ext;
  logic [C_AXIS_TUSER_WIDTH-1:0] r_tuser;
  logic                    r_last;
  logic [11:0]             r_vlan;
  logic [15:0][ENT_W-1:0]  r_tbl;
  logic [ENT_W-1:0]        r_entry, w_ctrl_entry;
  logic [3:0]              r_addr;
  logic [C_PKT_VEC_WIDTH-1:0] r_phv, w_phv;
  logic [15:0]             w_act;
  logic [47:0]             w_val;
  logic                    w_fwd_en, w_xfer, w_tbl_we, w_unused;

  assign w_fwd_en      = ~areset & (r_state != LOOKUP) & (r_state != EXTRACT) & (r_state != EMIT_PHV);
  assign s_axis_tready = m_axis_tready & w_fwd_en;
  assign m_axis_tvalid = s_axis_tvalid & w_fwd_en;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign w_xfer        = s_axis_tvalid & s_axis_tready;
  assign phv_out       = r_phv;
  assign phv_valid     = (r_state == EMIT_PHV);
  assign w_unused      = ^{ctrl_s_axis_tdata[DW-1:ENT_W], ctrl_s_axis_tuser, ctrl_s_axis_tkeep,
                           ctrl_s_axis_tlast, r_entry, w_act};

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state  <= HDR_0;
      r_cstate <= C_IDLE;
    end else begin
      r_state  <= w_state_nxt;
      r_cstate <= w_cstate_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HDR_0:    if (w_xfer) w_state_nxt = s_axis_tlast ? LOOKUP : HDR_1;
      HDR_1:    if (w_xfer) w_state_nxt = s_axis_tlast ? LOOKUP : HDR_2;
      HDR_2:    if (w_xfer) w_state_nxt = s_axis_tlast ? LOOKUP : HDR_3;
      HDR_3:    if (w_xfer) w_state_nxt = LOOKUP;
      LOOKUP:   w_state_nxt = EXTRACT;
      EXTRACT:  w_state_nxt = EMIT_PHV;
      EMIT_PHV: if (phv_ready) w_state_nxt = r_last ? HDR_0 : PAYLOAD;
      PAYLOAD:  if (w_xfer && s_axis_tlast) w_state_nxt = HDR_0;
      default:  w_state_nxt = HDR_0;
    endcase
  end

  // Beat 0 clears the upper slices so bytes of beats never received read as zero.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_hdr   <= '0;
      r_tuser <= '0;
      r_last  <= 1'b0;
      r_vlan  <= '0;
      r_entry <= '0;
      r_phv   <= '0;
    end else begin
      if (w_xfer) begin
        case (r_state)
          HDR_0: begin
            r_hdr   <= {{(BUF_W-DW){1'b0}}, s_axis_tdata};
            r_tuser <= s_axis_tuser;
            r_last  <= s_axis_tlast;
            r_vlan  <= {s_axis_tdata[112+:4], s_axis_tdata[120+:8]};
          end
          HDR_1: begin r_hdr[1*DW+:DW] <= s_axis_tdata; r_last <= s_axis_tlast; end
          HDR_2: begin r_hdr[2*DW+:DW] <= s_axis_tdata; r_last <= s_axis_tlast; end
          HDR_3: begin r_hdr[3*DW+:DW] <= s_axis_tdata; r_last <= s_axis_tlast; end
          default: ;
        endcase
      end
      if (r_state == LOOKUP)  r_entry <= r_tbl[r_vlan[7:4]];
      if (r_state == EXTRACT) r_phv   <= w_phv;
    end
  end

  // Six-byte big-endian window starting at byte o; bytes past the buffer come from zero padding.
  function automatic logic [47:0] win6(input logic [BUF_W+47:0] ext, input logic [6:0] o);
    logic [47:0] v;
    v = '0;
    for (int k = 0; k < 6; k++) v[8*(5-k)+:8] = ext[8*(int'(o)+k)+:8];
    return v;
  endfunction

  assign w_ext = {48'b0, r_hdr};

  // Actions applied in ascending order so the higher index wins a shared container.
  always_comb begin
    w_phv = '0;
    w_act = '0;
    w_val = '0;
    w_phv[0+:C_AXIS_TUSER_WIDTH] = r_tuser;
    w_phv[129+:12] = r_vlan;
    for (int i = 0; i < 10; i++) begin
      w_act = r_entry[144-16*i+:16];
      w_val = win6(w_ext, w_act[12:6]);
      if (w_act[0]) begin
        case (w_act[5:4])
          2'b01:   w_phv[356+16*w_act[3:1]+:16] = w_val[47:32];
          2'b10:   w_phv[484+32*w_act[3:1]+:32] = w_val[47:16];
          2'b11:   w_phv[740+48*w_act[3:1]+:48] = w_val;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_cstate_nxt = r_cstate;
    if (ctrl_s_axis_tvalid) begin
      case (r_cstate)
        C_IDLE:  w_cstate_nxt = C_HDR;
        C_HDR:   w_cstate_nxt = (ctrl_s_axis_tdata[112+:3] == PARSER_MOD_ID) ? C_DATA : C_IDLE;
        default: w_cstate_nxt = C_IDLE;
      endcase
    end
  end

  // Entry byte j is control byte 19-j: the upper 160 bits of the byte-reversed beat.
  always_comb begin
    w_ctrl_entry = '0;
    for (int j = 0; j < ENT_W/8; j++) w_ctrl_entry[8*j+:8] = ctrl_s_axis_tdata[8*(19-j)+:8];
  end

  assign w_tbl_we = ctrl_s_axis_tvalid & (r_cstate == C_DATA);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_addr <= '0;
      r_tbl  <= '0;
    end else begin
      if (ctrl_s_axis_tvalid && r_cstate == C_HDR && ctrl_s_axis_tdata[112+:3] == PARSER_MOD_ID)
        r_addr <= ctrl_s_axis_tdata[128+:4];
      if (w_tbl_we) r_tbl[r_addr] <= w_ctrl_entry;
    end
  end
endmodule

// File: tb/tb_hdr_parser.sv
// Directed bench for hdr_parser: table programming, field extraction, pass-through,
// backpressure and mid-packet reset, against hand-computed PHV images.
module tb_hdr_parser;
  logic clk = 1'b0;
  logic areset = 1'b1;
  logic [255:0] s_axis_tdata, m_axis_tdata, ctrl_s_axis_tdata;
  logic [31:0]  s_axis_tkeep, m_axis_tkeep, ctrl_s_axis_tkeep;
  logic [127:0] s_axis_tuser, m_axis_tuser, ctrl_s_axis_tuser;
  logic s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic ctrl_s_axis_tvalid, ctrl_s_axis_tlast;
  logic [1123:0] phv_out;
  logic phv_valid, phv_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int n_last  = 0;

  always #5 clk = ~clk;

  hdr_parser dut (
    .clk(clk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .phv_out(phv_out), .phv_valid(phv_valid), .phv_ready(phv_ready),
    .ctrl_s_axis_tdata(ctrl_s_axis_tdata), .ctrl_s_axis_tuser(ctrl_s_axis_tuser),
    .ctrl_s_axis_tkeep(ctrl_s_axis_tkeep), .ctrl_s_axis_tvalid(ctrl_s_axis_tvalid),
    .ctrl_s_axis_tlast(ctrl_s_axis_tlast)
  );

  always @(posedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      n_out <= n_out + 1;
      if (m_axis_tlast) n_last <= n_last + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {511'b0, obs}, {511'b0, exp});
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    chk(tag, {480'b0, obs}, {480'b0, exp});
  endtask

  task automatic chk_phv(input string tag, input logic [1123:0] e);
    chk({tag, "_q3"}, {156'b0, phv_out[1123:768]}, {156'b0, e[1123:768]});
    chk({tag, "_q2"}, {256'b0, phv_out[767:512]},  {256'b0, e[767:512]});
    chk({tag, "_q1"}, {256'b0, phv_out[511:256]},  {256'b0, e[511:256]});
    chk({tag, "_q0"}, {256'b0, phv_out[255:0]},    {256'b0, e[255:0]});
  endtask

  function automatic logic [15:0] act(input logic [6:0] o, input logic [1:0] t, input logic [2:0] c);
    return {3'b000, o, t, c, 1'b1};
  endfunction

  function automatic logic [1123:0] base_phv(input logic [127:0] u, input logic [11:0] v);
    logic [1123:0] p;
    p = '0;
    p[0+:128]  = u;
    p[129+:12] = v;
    return p;
  endfunction

  // Presents one beat, waits (bounded) for acceptance, checks the forwarded copy.
  task automatic send_beat(input logic [255:0] d, input logic [127:0] u, input logic l);
    int n;
    n = 0;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    #1;
    while (!s_axis_tready && n < 50) begin @(negedge clk); #1; n++; end
    chk1("beat_accepted", s_axis_tready, 1'b1);
    chk("beat_forwarded", {126'b0, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata},
        {126'b0, 1'b1, l, u, d});
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_phv(output int cyc);
    cyc = 0;
    while (!phv_valid && cyc < 30) begin @(negedge clk); #1; cyc++; end
    chk1("phv_valid_seen", phv_valid, 1'b1);
  endtask

  task automatic phv_hs();
    phv_ready = 1'b1;
    @(negedge clk);
    phv_ready = 1'b0;
    #1;
    chk1("phv_valid_drops", phv_valid, 1'b0);
  endtask

  // Header beat carries mod ID and address; data beat is byte-reversed with the entry on top.
  task automatic ctrl_write(input logic [3:0] a, input logic [159:0] e, input logic [2:0] mid);
    logic [255:0] sw, d;
    sw = {e, 96'b0};
    for (int k = 0; k < 32; k++) d[8*k+:8] = sw[8*(31-k)+:8];
    ctrl_s_axis_tvalid = 1'b1;
    ctrl_s_axis_tdata  = '0;
    @(negedge clk);
    ctrl_s_axis_tdata[114:112] = mid;
    ctrl_s_axis_tdata[131:128] = a;
    @(negedge clk);
    ctrl_s_axis_tdata = d;
    @(negedge clk);
    ctrl_s_axis_tdata = '0;
    // a rejected header leaves the data beat to re-arm the FSM; one zero beat returns it to idle
    if (mid != 3'b001) @(negedge clk);
    ctrl_s_axis_tvalid = 1'b0;
  endtask

  initial begin
    logic [255:0] d, d1, d2, d3;
    logic [159:0] e;
    logic [127:0] u;
    logic [1123:0] exp, p0;
    logic ok_a, ok_b, ok_c;
    int cyc, n0, l0;

    s_axis_tdata = '0; s_axis_tkeep = '1; s_axis_tuser = '0; s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1; phv_ready = 1'b0;
    ctrl_s_axis_tdata = '0; ctrl_s_axis_tuser = '0; ctrl_s_axis_tkeep = '1;
    ctrl_s_axis_tvalid = 1'b0; ctrl_s_axis_tlast = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_s_tready", s_axis_tready, 1'b0);
    chk1("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk1("rst_phv_valid", phv_valid, 1'b0);
    chk_phv("rst_phv", '0);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    #1;
    chk1("idle_s_tready", s_axis_tready, 1'b1);

    // A: entry 2, 2B c0 from bytes 12..13, single-beat packet with VID 0x025
    e = '0;
    e[144+:16] = act(7'd12, 2'b01, 3'd0);
    ctrl_write(4'd2, e, 3'b001);
    d = '0;
    d[8*12+:8] = 8'h08; d[8*13+:8] = 8'h00; d[8*15+:8] = 8'h25;
    u = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    n0 = n_out; l0 = n_last;
    send_beat(d, u, 1'b1);
    wait_phv(cyc);
    chk32("A_latency", cyc + 1, 3);
    exp = base_phv(u, 12'h025);
    exp[356+:16] = 16'h0800;
    chk_phv("A_phv", exp);
    chk32("A_beats", n_out - n0, 1);
    chk32("A_lasts", n_last - l0, 1);
    chk1("A_emit_blocks_input", s_axis_tready, 1'b0);
    phv_hs();
    chk1("A_back_to_hdr0", s_axis_tready, 1'b1);

    // B: 4 header beats + 3 payload, 6B at byte 126, override order, invalid action ignored
    e = '0;
    e[144+:16] = act(7'd126, 2'b11, 3'd7);
    e[112+:16] = act(7'd0, 2'b01, 3'd1);
    e[64+:16]  = act(7'd2, 2'b01, 3'd1);
    e[0+:16]   = act(7'd0, 2'b01, 3'd1) & 16'hFFFE;
    ctrl_write(4'd3, e, 3'b001);
    d = '0;  d[8*0+:8] = 8'h11; d[8*1+:8] = 8'h22; d[8*2+:8] = 8'h33; d[8*3+:8] = 8'h44;
    d[8*15+:8] = 8'h30;
    d1 = {8{32'hF0F0_F0F0}};
    d2 = '0; d2[8*0+:8] = 8'hDE; d2[8*1+:8] = 8'hAD; d2[8*2+:8] = 8'hBE; d2[8*3+:8] = 8'hEF;
    d3 = '0; d3[8*29+:8] = 8'h77; d3[8*30+:8] = 8'hAB; d3[8*31+:8] = 8'hCD;
    u = 128'hB;
    n0 = n_out; l0 = n_last;
    send_beat(d, u, 1'b0);
    send_beat(d1, 128'h1, 1'b0);
    send_beat(d2, 128'h2, 1'b0);
    send_beat(d3, 128'h3, 1'b0);
    wait_phv(cyc);
    exp = base_phv(u, 12'h030);
    exp[372+:16]  = 16'h3344;
    exp[1076+:48] = 48'hABCD_0000_0000;
    chk_phv("B_phv", exp);
    phv_hs();
    send_beat({8{32'h5555_5555}}, 128'h4, 1'b0);
    send_beat({8{32'h6666_6666}}, 128'h5, 1'b0);
    send_beat({8{32'h7777_7777}}, 128'h6, 1'b1);
    chk32("B_beats", n_out - n0, 7);
    chk32("B_lasts", n_last - l0, 1);

    // C: 2-beat packet; bytes 64.. lie in a beat not received and read as zero
    e = '0;
    e[144+:16] = act(7'd64, 2'b10, 3'd2);
    e[128+:16] = act(7'd60, 2'b10, 3'd3);
    ctrl_write(4'd4, e, 3'b001);
    d = '0; d[8*15+:8] = 8'h40;
    d1 = '0; d1[8*28+:8] = 8'h01; d1[8*29+:8] = 8'h02; d1[8*30+:8] = 8'h03; d1[8*31+:8] = 8'h04;
    u = 128'hC0C0;
    n0 = n_out;
    send_beat(d, u, 1'b0);
    send_beat(d1, 128'hC1, 1'b1);
    wait_phv(cyc);
    exp = base_phv(u, 12'h040);
    exp[580+:32] = 32'h0102_0304;
    chk_phv("C_phv", exp);
    phv_hs();
    chk32("C_beats", n_out - n0, 2);

    // D: output and PHV backpressure
    d = '0; d[8*12+:8] = 8'h08; d[8*15+:8] = 8'h25;
    u = 128'hD0D0;
    n0 = n_out;
    m_axis_tready = 1'b0;
    s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
    ok_a = 1'b1; ok_b = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      ok_a &= !s_axis_tready;
      ok_b &= m_axis_tvalid;
    end
    chk1("D_stall_tready_low", ok_a, 1'b1);
    chk1("D_stall_tvalid_held", ok_b, 1'b1);
    chk32("D_stall_no_beat", n_out - n0, 0);
    m_axis_tready = 1'b1;
    send_beat(d, u, 1'b1);
    wait_phv(cyc);
    m_axis_tready = 1'b0;
    p0 = phv_out;
    s_axis_tdata = '1; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
    ok_a = 1'b1; ok_b = 1'b1; ok_c = 1'b1;
    repeat (10) begin
      @(negedge clk); #1;
      ok_a &= !s_axis_tready;
      ok_b &= (phv_out === p0);
      ok_c &= phv_valid;
    end
    chk1("D_hold_tready_low", ok_a, 1'b1);
    chk1("D_hold_phv_stable", ok_b, 1'b1);
    chk1("D_hold_phv_valid", ok_c, 1'b1);
    exp = base_phv(u, 12'h025);
    exp[356+:16] = 16'h0800;
    chk_phv("D_phv", exp);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    phv_hs();
    chk32("D_beats", n_out - n0, 1);

    // E: wrong module ID ignored, matching ID updates entry 2
    e = '0;
    e[144+:16] = act(7'd0, 2'b01, 3'd0);
    ctrl_write(4'd2, e, 3'b101);
    d = '0; d[8*0+:8] = 8'h5A; d[8*1+:8] = 8'hA5; d[8*12+:8] = 8'h08; d[8*15+:8] = 8'h25;
    u = 128'hE1;
    send_beat(d, u, 1'b1);
    wait_phv(cyc);
    exp = base_phv(u, 12'h025);
    exp[356+:16] = 16'h0800;
    chk_phv("E_old_entry", exp);
    phv_hs();
    ctrl_write(4'd2, e, 3'b001);
    u = 128'hE2;
    send_beat(d, u, 1'b1);
    wait_phv(cyc);
    exp = base_phv(u, 12'h025);
    exp[356+:16] = 16'h5AA5;
    chk_phv("E_new_entry", exp);
    phv_hs();

    // F: reset in HDR_2, next beat is a fresh packet against the cleared table
    d = '0; d[8*15+:8] = 8'h25;
    send_beat(d, 128'hF0, 1'b0);
    send_beat({8{32'h1234_5678}}, 128'hF1, 1'b0);
    s_axis_tdata = {8{32'h9ABC_DEF0}}; s_axis_tvalid = 1'b1;
    areset = 1'b1;
    #1;
    chk1("F_rst_s_tready", s_axis_tready, 1'b0);
    chk1("F_rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk1("F_rst_phv_valid", phv_valid, 1'b0);
    @(negedge clk);
    areset = 1'b0;
    s_axis_tvalid = 1'b0;
    d = '0; d[8*12+:8] = 8'h08; d[8*13+:8] = 8'h99; d[8*15+:8] = 8'h25;
    u = 128'hF2F2;
    send_beat(d, u, 1'b1);
    wait_phv(cyc);
    chk32("F_latency", cyc + 1, 3);
    chk_phv("F_phv", base_phv(u, 12'h025));
    phv_hs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
